// File: rtl/qr_gg_seq_if.sv
// Stream bundle for the GG sequencer: element input, GG
// drive/capture and rotation-word output.
interface qr_gg_seq_if #(
    parameter int CW = 2,
    parameter int RW = 2
);
    logic          s_valid;
    logic          s_ready;
    logic [12:0]   s_data;
    logic [12:0]   gg_data;
    logic          gg_first;
    logic          gg_last;
    logic [11:0]   gg_di;
    logic          r_valid;
    logic          r_ready;
    logic [11:0]   r_di;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    modport master (
        output s_valid, s_data, gg_di, r_ready,
        input  s_ready, gg_data, gg_first, gg_last,
        input  r_valid, r_di, r_col, r_row
    );

    modport slave (
        input  s_valid, s_data, gg_di, r_ready,
        output s_ready, gg_data, gg_first, gg_last,
        output r_valid, r_di, r_col, r_row
    );
endinterface

// File: rtl/qr_gg_seq.sv
// Column sequencer for the GG boundary cell: buffers a column,
// bursts it gaplessly into GG, queues returned direction bits.
module qr_gg_seq #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DI_LAT   = 2,
    parameter int RF_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    qr_gg_seq_if.slave bus
);
    localparam int NCOL = (ROWS < COLS) ? ROWS : COLS;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = $clog2(ROWS);
    localparam int PW   = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int FW   = $clog2(RF_DEPTH + 1);
    localparam int IW   = $clog2(DI_LAT + 2);
    localparam int EW   = CW + RW + 12;

    typedef enum logic [2:0] {
        IDLE, FILL, WAIT_CRED, ISSUE, FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] j_q, j_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] n_last;
    logic [12:0]   colbuf_q [ROWS];

    logic [12:0]   gg_data_q, gg_data_d;
    logic          gg_first_q, gg_first_d;
    logic          gg_last_q, gg_last_d;
    logic          done_q, done_d;

    logic          tag_v;
    logic [RW-1:0] tag_row;
    logic          pv_q [DI_LAT+1];
    logic [CW-1:0] pc_q [DI_LAT+1];
    logic [RW-1:0] pr_q [DI_LAT+1];
    logic [IW-1:0] infl;

    logic [EW-1:0] mem_q [RF_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [FW-1:0] fcnt_q;
    logic          push, pop, empty, cred_ok;

    assign n_last = RW'(ROWS - 1) - j_q;

    always_comb begin
        infl = '0;
        for (int k = 0; k <= DI_LAT; k++)
            infl = infl + IW'(pv_q[k]);
    end

    // Reserve room for every word the column can produce
    // before the first element leaves, since GG cannot stall.
    assign cred_ok = (32'(fcnt_q) + 32'(infl) + 32'(n_last))
                     <= 32'(RF_DEPTH);

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        gg_data_d  = '0;
        gg_first_d = 1'b0;
        gg_last_d  = 1'b0;
        tag_v      = 1'b0;
        tag_row    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    j_d     = '0;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (bus.s_valid) begin
                    if (cnt_q == n_last) begin
                        state_d = WAIT_CRED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + RW'(1);
                    end
                end
            end
            WAIT_CRED: begin
                if (cred_ok)
                    state_d = ISSUE;
            end
            ISSUE: begin
                gg_data_d  = colbuf_q[cnt_q];
                gg_first_d = (cnt_q == '0);
                gg_last_d  = (cnt_q == n_last);
                tag_v      = (cnt_q != '0);
                tag_row    = j_q + cnt_q;
                if (cnt_q == n_last) begin
                    cnt_d = '0;
                    if (j_q == RW'(NCOL - 1)) begin
                        state_d = FLUSH;
                    end else begin
                        j_d     = j_q + RW'(1);
                        state_d = FILL;
                    end
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            FLUSH: begin
                if (infl == '0 && empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            j_q        <= '0;
            cnt_q      <= '0;
            gg_data_q  <= '0;
            gg_first_q <= 1'b0;
            gg_last_q  <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                colbuf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            gg_data_q  <= gg_data_d;
            gg_first_q <= gg_first_d;
            gg_last_q  <= gg_last_d;
            done_q     <= done_d;
            if (state_q == FILL && bus.s_valid)
                colbuf_q[cnt_q] <= bus.s_data;
        end
    end

    // Tag stage k lines up with the k-th cycle after issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= DI_LAT; k++) begin
                pv_q[k] <= 1'b0;
                pc_q[k] <= '0;
                pr_q[k] <= '0;
            end
        end else begin
            pv_q[0] <= tag_v;
            pc_q[0] <= CW'(j_q);
            pr_q[0] <= tag_row;
            for (int k = 1; k <= DI_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pc_q[k] <= pc_q[k-1];
                pr_q[k] <= pr_q[k-1];
            end
        end
    end

    assign push  = pv_q[DI_LAT];
    assign empty = (fcnt_q == '0);
    assign pop   = !empty && bus.r_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= {pc_q[DI_LAT], pr_q[DI_LAT],
                                bus.gg_di};
                wp_q <= (wp_q == PW'(RF_DEPTH - 1)) ?
                        '0 : wp_q + PW'(1);
            end
            if (pop)
                rp_q <= (rp_q == PW'(RF_DEPTH - 1)) ?
                        '0 : rp_q + PW'(1);
            fcnt_q <= fcnt_q + FW'(push) - FW'(pop);
        end
    end

    a_no_ovf: assert property (@(posedge clk) disable iff (!reset)
        push |-> (fcnt_q != FW'(RF_DEPTH) || pop));

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign bus.s_ready  = (state_q == FILL);
    assign bus.gg_data  = gg_data_q;
    assign bus.gg_first = gg_first_q;
    assign bus.gg_last  = gg_last_q;
    assign bus.r_valid  = !empty;
    assign bus.r_di     = mem_q[rp_q][11:0];
    assign bus.r_row    = mem_q[rp_q][12 +: RW];
    assign bus.r_col    = mem_q[rp_q][12+RW +: CW];
endmodule
